// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: default datapath width,
// FSM state encoding and the doubleword alignment mask.
package mem_access_pkg;

  localparam int WORD_DEFAULT = 64;

  // Accesses are doublewords; any low address bit under this mask is misaligned.
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] addr_lo);
    return |(addr_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_access_ex_mem_reg.sv
// EX/MEM capture register: loads the whole execute-stage bundle on accept.
// Synchronous active-high reset clears it so every derived output reads zero.
module ex_mem_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cap_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cap_q <= '0;
    end else if (en_i) begin
      cap_q <= d_i;
    end
  end

  assign q_o = cap_q;

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: captures an execute result, performs an optional
// data-memory transaction, then holds the writeback result until wb_ready_i.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int WORD = WORD_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [WORD-1:0] alu_result_i,
  input  logic [WORD-1:0] write_data_i,
  input  logic [WORD-1:0] branch_target_i,
  input  logic            zero_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            branch_i,
  input  logic            uncond_branch_i,
  input  logic [4:0]      rd_i,
  output logic            dm_req_o,
  output logic            dm_we_o,
  output logic [WORD-1:0] dm_addr_o,
  output logic [WORD-1:0] dm_wdata_o,
  input  logic            dm_ack_i,
  input  logic [WORD-1:0] dm_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [WORD-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic            pc_src_o,
  output logic [WORD-1:0] pc_target_o,
  output logic            align_err_o
);

  typedef struct packed {
    logic [WORD-1:0] alu_result;
    logic [WORD-1:0] write_data;
    logic [WORD-1:0] branch_target;
    logic            zero;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            uncond_branch;
    logic [4:0]      rd;
  } op_t;

  op_t             op_in;
  op_t             op_q;
  state_e          state_q, state_d;
  logic            accept;
  logic            fresh_q;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            in_mem, in_mis;
  logic            cap_mem, cap_mis, cap_load_ok;

  assign op_in = '{
    alu_result:    alu_result_i,
    write_data:    write_data_i,
    branch_target: branch_target_i,
    zero:          zero_i,
    mem_read:      mem_read_i,
    mem_write:     mem_write_i,
    branch:        branch_i,
    uncond_branch: uncond_branch_i,
    rd:            rd_i
  };

  ex_mem_reg #(.W($bits(op_t))) u_ex_mem_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     (op_in),
    .q_o     (op_q)
  );

  assign in_mem      = mem_read_i | mem_write_i;
  assign in_mis      = is_misaligned(alu_result_i[2:0]);
  assign cap_mem     = op_q.mem_read | op_q.mem_write;
  assign cap_mis     = is_misaligned(op_q.alu_result[2:0]);
  assign cap_load_ok = op_q.mem_read & ~cap_mis;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      fresh_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      fresh_q <= accept;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ex_ready_o = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE:   ex_ready_o = 1'b1;
      ST_ACCESS: begin
        if (dm_ack_i) begin
          state_d = ST_HOLD;
          if (op_q.mem_read) rdata_d = dm_rdata_i;
        end
      end
      ST_HOLD: begin
        ex_ready_o = wb_ready_i;
        if (wb_ready_i) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    accept = ex_valid_i & ex_ready_o;
    // A new accept overrides the HOLD->IDLE drain so back-to-back ops never bubble.
    if (accept) state_d = (in_mem && !in_mis) ? ST_ACCESS : ST_HOLD;
  end

  assign dm_req_o   = (state_q == ST_ACCESS);
  assign dm_we_o    = dm_req_o & op_q.mem_write;
  assign dm_addr_o  = op_q.alu_result;
  assign dm_wdata_o = op_q.write_data;

  assign wb_valid_o     = (state_q == ST_HOLD);
  assign wb_data_o      = cap_load_ok ? rdata_q : op_q.alu_result;
  assign wb_rd_o        = op_q.rd;
  // Stores, branches and faulted (misaligned) accesses never write the register file.
  assign wb_reg_write_o = wb_valid_o & ~op_q.mem_write & ~op_q.branch
                        & ~op_q.uncond_branch & ~(cap_mem & cap_mis);

  assign pc_src_o    = fresh_q & ((op_q.branch & op_q.zero) | op_q.uncond_branch);
  assign pc_target_o = op_q.branch_target;
  assign align_err_o = fresh_q & cap_mem & cap_mis;

endmodule

// File: tb/tb_mem_access.sv
// Directed plus randomized check of mem_access against an operation-level model.
module tb_mem_access;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, ex_valid, ex_ready;
  logic [W-1:0] alu_result, write_data, branch_target;
  logic         zero, mem_read, mem_write, branch, uncond_branch;
  logic [4:0]   rd;
  logic         dm_req, dm_we, dm_ack;
  logic [W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         wb_valid, wb_ready, wb_reg_write, pc_src, align_err;
  logic [W-1:0] wb_data, pc_target;
  logic [4:0]   wb_rd;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.WORD(W)) dut (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .alu_result_i(alu_result), .write_data_i(write_data), .branch_target_i(branch_target),
    .zero_i(zero), .mem_read_i(mem_read), .mem_write_i(mem_write), .branch_i(branch),
    .uncond_branch_i(uncond_branch), .rd_i(rd),
    .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
    .dm_ack_i(dm_ack), .dm_rdata_i(dm_rdata),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .wb_reg_write_o(wb_reg_write), .pc_src_o(pc_src), .pc_target_o(pc_target),
    .align_err_o(align_err)
  );

  typedef struct {
    logic [W-1:0] a, wd, bt;
    logic         zero, mr, mw, br, ub;
    logic [4:0]   rd;
  } op_s;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 alu, 1 conditional branch, 2 unconditional branch, 3 load, 4 store
  function automatic op_s mk(input int kind, input logic [W-1:0] a, input logic [W-1:0] wd,
                             input logic [W-1:0] bt, input logic z, input logic [4:0] r);
    op_s o;
    o.a = a; o.wd = wd; o.bt = bt; o.zero = z; o.rd = r;
    o.br = (kind == 1); o.ub = (kind == 2); o.mr = (kind == 3); o.mw = (kind == 4);
    return o;
  endfunction

  task automatic scramble_inputs();
    alu_result    = {$urandom, $urandom};
    write_data    = {$urandom, $urandom};
    branch_target = {$urandom, $urandom};
    rd            = 5'($urandom);
    zero = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    branch = 1'($urandom); uncond_branch = 1'($urandom);
  endtask

  // Presents one op at a negedge (DUT must be IDLE or HOLD), follows it to HOLD,
  // then keeps wb_ready low for wait_cyc cycles. Returns with the DUT in HOLD.
  task automatic drive_op(input op_s o, input int n_ack, input logic [W-1:0] rdata,
                          input int wait_cyc);
    logic         is_mem, mis, exp_pc, exp_rw;
    logic [W-1:0] exp_wd;
    is_mem = o.mr | o.mw;
    mis    = (o.a[2:0] != 3'd0);
    exp_pc = (o.br & o.zero) | o.ub;
    exp_rw = is_mem ? (o.mr & ~mis) : ~(o.br | o.ub);
    exp_wd = (o.mr & ~mis) ? rdata : o.a;

    wb_ready = 1'b1; ex_valid = 1'b1;
    alu_result = o.a; write_data = o.wd; branch_target = o.bt; zero = o.zero;
    mem_read = o.mr; mem_write = o.mw; branch = o.br; uncond_branch = o.ub; rd = o.rd;
    #1 chk("ex_ready_at_accept", ex_ready, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    scramble_inputs();
    chk("pc_src_pulse", pc_src, exp_pc);
    chk("align_err_pulse", align_err, is_mem & mis);
    chk("pc_target", pc_target, o.bt);
    if (is_mem && !mis) begin
      for (int i = 1; i <= n_ack; i++) begin
        chk("dm_req_access", dm_req, 1'b1);
        chk("dm_addr", dm_addr, o.a);
        chk("dm_we", dm_we, o.mw);
        if (o.mw) chk("dm_wdata", dm_wdata, o.wd);
        chk("ex_ready_access", ex_ready, 1'b0);
        chk("wb_valid_access", wb_valid, 1'b0);
        if (i > 1) chk("pc_src_single", pc_src, 1'b0);
        dm_ack   = (i == n_ack);
        dm_rdata = (i == n_ack) ? rdata : {$urandom, $urandom};
        @(negedge clk);
      end
      dm_ack   = 1'b0;
      dm_rdata = {$urandom, $urandom};
    end
    chk("dm_req_after", dm_req, 1'b0);
    chk("wb_valid_hold", wb_valid, 1'b1);
    chk("wb_rd", wb_rd, o.rd);
    chk("wb_reg_write", wb_reg_write, exp_rw);
    if (exp_rw) chk("wb_data", wb_data, exp_wd);
    if (wait_cyc > 0) begin
      wb_ready = 1'b0;
      for (int k = 0; k < wait_cyc; k++) begin
        @(negedge clk);
        chk("hold_wb_valid", wb_valid, 1'b1);
        chk("hold_wb_rd", wb_rd, o.rd);
        chk("hold_wb_reg_write", wb_reg_write, exp_rw);
        if (exp_rw) chk("hold_wb_data", wb_data, exp_wd);
        chk("hold_ex_ready", ex_ready, 1'b0);
        chk("hold_pc_src", pc_src, 1'b0);
        chk("hold_align_err", align_err, 1'b0);
        chk("hold_dm_req", dm_req, 1'b0);
        dm_ack = 1'($urandom);
      end
      dm_ack = 1'b0;
    end
  endtask

  task automatic drain();
    wb_ready = 1'b1; ex_valid = 1'b0;
    dm_ack = 1'($urandom);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("drain_wb_valid", wb_valid, 1'b0);
    chk("drain_dm_req", dm_req, 1'b0);
    chk("drain_ex_ready", ex_ready, 1'b1);
    chk("drain_pc_src", pc_src, 1'b0);
  endtask

  initial begin
    int           kind;
    logic [W-1:0] a;

    reset = 1'b1; ex_valid = 1'b0; wb_ready = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_dm_we", dm_we, 1'b0);
    chk("rst_dm_addr", dm_addr, '0);
    chk("rst_dm_wdata", dm_wdata, '0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_wb_rd", wb_rd, '0);
    chk("rst_pc_src", pc_src, 1'b0);
    chk("rst_pc_target", pc_target, '0);
    chk("rst_align_err", align_err, 1'b0);

    drive_op(mk(0, 64'h2A, 64'h55, 64'h0, 1'b0, 5'd3), 1, '0, 0);
    drain();
    drive_op(mk(3, 64'h100, 64'h0, 64'h0, 1'b0, 5'd7), 3, 64'hDEAD, 0);
    drain();
    drive_op(mk(4, 64'h104, 64'h77, 64'h0, 1'b0, 5'd1), 1, '0, 0);
    drain();
    drive_op(mk(4, 64'h108, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 5'd2), 2, '0, 0);
    drain();
    drive_op(mk(1, 64'h0, 64'h0, 64'h40, 1'b1, 5'd0), 1, '0, 0);
    drain();
    drive_op(mk(1, 64'h0, 64'h0, 64'h40, 1'b0, 5'd0), 1, '0, 0);
    drain();
    drive_op(mk(0, 64'hCAFE, 64'h0, 64'h80, 1'b0, 5'd9), 1, '0, 4);
    drive_op(mk(3, 64'h200, 64'h0, 64'h0, 1'b0, 5'd12), 2, 64'hBEEF, 0);
    drive_op(mk(2, 64'h11, 64'h0, 64'hC0, 1'b0, 5'd4), 1, '0, 1);
    drain();

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      a    = {$urandom, $urandom};
      if (kind >= 3 && $urandom_range(0, 9) < 7) a[2:0] = 3'd0;
      drive_op(mk(kind, a, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                  5'($urandom)),
               $urandom_range(1, 4), {$urandom, $urandom},
               ($urandom_range(0, 3) == 3) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    // Reset beats a simultaneous accept and dm_ack.
    reset = 1'b1; ex_valid = 1'b1; dm_ack = 1'b1; wb_ready = 1'b1;
    alu_result = 64'h99; rd = 5'd5; mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b0; uncond_branch = 1'b1; branch_target = 64'h500;
    @(negedge clk);
    reset = 1'b0; ex_valid = 1'b0; dm_ack = 1'b0;
    chk("rstpri_wb_valid", wb_valid, 1'b0);
    chk("rstpri_pc_src", pc_src, 1'b0);
    chk("rstpri_wb_rd", wb_rd, '0);
    chk("rstpri_pc_target", pc_target, '0);
    chk("rstpri_ex_ready", ex_ready, 1'b1);

    // Reset during the second ACCESS cycle, then a late dm_ack.
    ex_valid = 1'b1; alu_result = 64'h300; mem_read = 1'b1; mem_write = 1'b0;
    branch = 1'b0; uncond_branch = 1'b0; rd = 5'd6; branch_target = 64'h900;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("midrst_dm_req_c1", dm_req, 1'b1);
    @(negedge clk);
    chk("midrst_dm_req_c2", dm_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_dm_req_drop", dm_req, 1'b0);
    chk("midrst_wb_valid", wb_valid, 1'b0);
    chk("midrst_ex_ready", ex_ready, 1'b1);
    dm_ack = 1'b1; dm_rdata = 64'hF00D;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("lateack_wb_valid", wb_valid, 1'b0);
    chk("lateack_dm_req", dm_req, 1'b0);
    chk("lateack_ex_ready", ex_ready, 1'b1);
    chk("lateack_dm_addr", dm_addr, '0);
    chk("lateack_wb_data", wb_data, '0);
    chk("lateack_pc_target", pc_target, '0);
    @(negedge clk);
    chk("lateack_wb_valid2", wb_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter WORD, default 64 from definitions.vh, datapath width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_valid  in  1  execute-stage result present.
REQ-005 ex_ready  out  1  block accepts execute result this cycle.
REQ-006 alu_result  in  WORD  address or ALU result.
REQ-007 write_data  in  WORD  store data (register read_data2).
REQ-008 branch_target  in  WORD  computed branch address.
REQ-009 zero  in  1  ALU zero flag.
REQ-010 mem_read, mem_write, branch, uncond_branch  in  1 each  decoded control bits.
REQ-011 rd  in  5  destination register index.
REQ-012 dm_req  out  1  data-memory request; dm_we  out  1  write enable; dm_addr, dm_wdata  out  WORD.
REQ-013 dm_ack  in  1  memory completion; dm_rdata  in  WORD  load data, valid with dm_ack.
REQ-014 wb_valid  out  1; wb_ready  in  1; wb_data  out  WORD; wb_rd  out  5; wb_reg_write  out  1.
REQ-015 pc_src  out  1  take-branch pulse; pc_target  out  WORD.
REQ-016 align_err  out  1  misaligned-access pulse.

Function
REQ-017 FSM states IDLE, ACCESS, HOLD; transfer into block occurs when ex_valid and ex_ready are both high.
REQ-018 ex_ready high in IDLE, and in HOLD when wb_ready is high (back-to-back accept); low in ACCESS.
REQ-019 On accept, all inputs are captured in one internal register; outputs derive only from captured values.
REQ-020 Non-memory op: IDLE/HOLD -> HOLD; wb_valid high the cycle after accept, wb_data = captured alu_result, wb_reg_write = 1 unless captured control is a store or branch.
REQ-021 Memory op with alu_result[2:0] == 0: -> ACCESS; dm_req high from the cycle after accept until and including the dm_ack cycle; dm_addr, dm_we, dm_wdata held stable while dm_req is high.
REQ-022 In ACCESS on dm_ack: -> HOLD; for loads wb_data = dm_rdata registered, wb_reg_write = 1; for stores wb_reg_write = 0.
REQ-023 Memory op with alu_result[2:0] != 0: no dm_req; align_err single-cycle pulse the cycle after accept; result goes to HOLD with wb_reg_write = 0.
REQ-024 HOLD: wb_valid, wb_data, wb_rd, wb_reg_write stable until wb_ready; on wb_ready without new accept -> IDLE; with new accept -> per REQ-020..023.
REQ-025 pc_src = (branch & zero) | uncond_branch of the captured op, single-cycle pulse the cycle after accept; pc_target = captured branch_target, held until next accept.
REQ-026 dm_ack while not in ACCESS is ignored.
REQ-027 Latency: non-memory 1 cycle to wb_valid; memory 1 + N cycles where N = cycles from dm_req rise to dm_ack, plus 1.

Reset
REQ-028 Reset forces IDLE; dm_req, dm_we, wb_valid, wb_reg_write, pc_src, align_err = 0; dm_addr, dm_wdata, wb_data, pc_target = 0; wb_rd = 0.
REQ-029 Reset asserted mid-ACCESS drops dm_req the following cycle; a later dm_ack produces no wb_valid.
REQ-030 Reset has priority over a simultaneous accept or dm_ack.

Structure
REQ-031 WORD, FSM state encoding, and the alignment mask constant reside in definitions.vh.
REQ-032 One sub-module ex_mem_reg holds the capture register (enable, sync reset); FSM and output muxing stay in mem_access.

Verification
REQ-033 ALU op alu_result=0x2A, rd=3, wb_ready=1 -> wb_valid next cycle, wb_data=0x2A, wb_rd=3, wb_reg_write=1, no dm_req.
REQ-034 Load addr=0x100, dm_ack 3 cycles after dm_req, dm_rdata=0xDEAD -> dm_req high exactly 3 cycles, wb_data=0xDEAD next cycle, ex_ready low throughout ACCESS.
REQ-035 Store addr=0x104 -> align_err pulse, no dm_req, wb_reg_write=0; store addr=0x108 -> dm_we=1, dm_wdata=write_data.
REQ-036 Branch=1, zero=1, branch_target=0x40 -> pc_src 1-cycle pulse, pc_target=0x40; zero=0 -> pc_src stays 0.
REQ-037 wb_ready low 4 cycles in HOLD -> outputs stable, ex_ready low; wb_ready high with ex_valid -> next op accepted same cycle.
REQ-038 Reset in second ACCESS cycle, dm_ack one cycle later -> dm_req 0, no wb_valid, state IDLE.
